seq_mult: RTL and testbench

SEQ_MULT -- requirements
Module: seq_mult

---
 rtl/multdiv_pkg.sv | 16 +
 rtl/seq_mult_ctrl.sv | 68 ++++++
 rtl/seq_mult.sv | 110 +++++++++++
 tb/tb_seq_mult.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the sequential multiply/divide units:
// FSM state encoding and the iteration-counter width helper.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Counter must hold the value WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control for seq_mult: FSM, iteration counter, ready/done,
// and the load/step/finish strobes that steer the datapath.
module seq_mult_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic ready,
    output logic done,
    output logic load,
    output logic step,
    output logic finish
);

    localparam int CW = cnt_width(WIDTH);

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state and datapath strobes; one extra CALC edge with
    // cnt==0 latches the result, giving fixed WIDTH+1 latency.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = CALC;
                end else begin
                    state_nx = IDLE;
                end
            end
            CALC: begin
                if (cnt != '0) begin
                    step = 1'b1;
                end else begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Iteration counter: loaded on accept, counts down per step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)     cnt <= '0;
        else if (load) cnt <= CW'(WIDTH);
        else if (step) cnt <= cnt - CW'(1);
    end

    assign ready = (state == IDLE) || (state == DONE);
    assign done  = (state == DONE);

endmodule

// File: rtl/seq_mult.sv
// Radix-2 sequential shift-add multiplier, WIDTH+1 cycle latency.
// Optional signed mode enabled by defining SEQ_MULT_SIGNED_EN.
module seq_mult
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             ovf
);

    localparam int W2 = 2 * WIDTH;

    logic             load;
    logic             step;
    logic             finish;
    logic [W2-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [W2-1:0]    acc;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [W2-1:0]    res;
    logic             ovf_c;

    seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .ready  (ready),
        .done   (done),
        .load   (load),
        .step   (step),
        .finish (finish)
    );

`ifdef SEQ_MULT_SIGNED_EN
    logic neg;
    logic sgn_q;

    // Operand magnitudes; result sign restored when entering DONE.
    always_comb begin
        mag_a = (sgn && a[WIDTH-1]) ? -a : a;
        mag_b = (sgn && b[WIDTH-1]) ? -b : b;
        res   = neg ? -acc : acc;
        if (sgn_q)
            ovf_c = res[W2-1:WIDTH] != {WIDTH{res[WIDTH-1]}};
        else
            ovf_c = |res[W2-1:WIDTH];
    end

    // Sign bookkeeping captured with the operands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            neg   <= 1'b0;
            sgn_q <= 1'b0;
        end else if (load) begin
            neg   <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            sgn_q <= sgn;
        end
    end
`else
    logic unused_sgn;
    assign unused_sgn = sgn;

    // Unsigned only: operands pass straight through.
    always_comb begin
        mag_a = a;
        mag_b = b;
        res   = acc;
        ovf_c = |acc[W2-1:WIDTH];
    end
`endif

    // Shift-add datapath: one multiplier bit consumed per step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
        end else if (step) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // Result registers, updated only on entry to DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            product <= '0;
            ovf     <= 1'b0;
        end else if (finish) begin
            product <= res[WIDTH-1:0];
            ovf     <= ovf_c;
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult (WIDTH=32): directed and random
// operations checked against an arithmetic reference model.
module tb_seq_mult;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clock;
    logic         reset;
    logic         start;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] product;
    logic         ovf;

    int total;
    int bad;

    seq_mult #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .sgn     (sgn),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .product (product),
        .ovf     (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: full 2W-bit product from plain arithmetic.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic ms, output logic [W-1:0] mp,
                         output logic mo);
        logic [63:0] xa, xb, full;
        logic        signed_mode;
`ifdef SEQ_MULT_SIGNED_EN
        signed_mode = ms;
`else
        signed_mode = 1'b0;
`endif
        xa = signed_mode ? {{W{ma[W-1]}}, ma} : {{W{1'b0}}, ma};
        xb = signed_mode ? {{W{mb[W-1]}}, mb} : {{W{1'b0}}, mb};
        full = xa * xb;
        mp = full[W-1:0];
        if (signed_mode) mo = full[63:W] != {W{full[W-1]}};
        else             mo = full[63:W] != '0;
    endtask

    // Called #1 after a rising edge; returns #1 after the done edge.
    task automatic run(input logic [W-1:0] ra, input logic [W-1:0] rb,
                       input logic rs);
        logic [W-1:0] ep;
        logic         eo;
        int           n;
        model(ra, rb, rs, ep, eo);
        check("ready_before", {63'b0, ready}, 64'd1);
        a = ra; b = rb; sgn = rs; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; sgn = $urandom_range(0, 1);
        check("done_low_after_accept", {63'b0, done}, 64'd0);
        n = 0;
        while (n < LAT + 8) begin
            @(posedge clock); #1;
            n++;
            if (done) break;
        end
        check("latency", 64'(n), 64'(LAT));
        check("product", {32'b0, product}, {32'b0, ep});
        check("ovf", {63'b0, ovf}, {63'b0, eo});
    endtask

    task automatic idle_gap();
        @(posedge clock); #1;
        check("done_single", {63'b0, done}, 64'd0);
        check("ready_idle", {63'b0, ready}, 64'd1);
    endtask

    initial begin
        int ndone;
        total = 0; bad = 0;
        reset = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        #12;
        check("rst_ready", {63'b0, ready}, 64'd1);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_product", {32'b0, product}, 64'd0);
        check("rst_ovf", {63'b0, ovf}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        run(32'h0, 32'hFFFFFFFF, 1'b0);
        check("zero_prod", {32'b0, product}, 64'd0);
        check("zero_ovf", {63'b0, ovf}, 64'd0);
        idle_gap();

        run(32'd123, 32'd321, 1'b0);
        check("b2b1_prod", {32'b0, product}, 64'd39483);
        run(32'h100, 32'h100, 1'b0);
        check("b2b2_prod", {32'b0, product}, 64'h10000);
        check("b2b2_ovf", {63'b0, ovf}, 64'd0);
        idle_gap();

        run(32'h40000000, 32'h40000000, 1'b0);
        check("big_prod", {32'b0, product}, 64'd0);
        check("big_ovf", {63'b0, ovf}, 64'd1);
        idle_gap();

        run(32'hFFFFFD72, 32'd123, 1'b1);
        check("neg_prod", {32'b0, product}, 64'hFFFEC5C6);
`ifdef SEQ_MULT_SIGNED_EN
        check("neg_ovf", {63'b0, ovf}, 64'd0);
`else
        check("neg_ovf", {63'b0, ovf}, 64'd1);
`endif
        idle_gap();

        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) ra = ra >> 20;
            if (i % 4 == 2) rb = rb >> 24;
            run(ra, rb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_gap();
        end
        idle_gap();

        // Abort: start, ignored start mid-CALC, then reset.
        a = 32'd7; b = 32'd9; sgn = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        a = 32'd5; b = 32'd5; start = 1'b1;
        check("calc_not_ready", {63'b0, ready}, 64'd0);
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("calc_still_busy", {63'b0, ready}, 64'd0);
        reset = 1'b1;
        #1;
        check("abort_ready", {63'b0, ready}, 64'd1);
        check("abort_product", {32'b0, product}, 64'd0);
        check("abort_ovf", {63'b0, ovf}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        ndone = 0;
        repeat (LAT + 10) begin
            @(posedge clock); #1;
            if (done) ndone++;
        end
        check("no_done_after_abort", 64'(ndone), 64'd0);

        run(32'hDEADBEEF, 32'h12345, 1'b1);
        idle_gap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
